// File: rtl/clk_ratio_checker_if.sv
// Divided-clock inputs and lock/error status of clk_ratio_checker.
// master drives the clocks under test; slave is the checker.
interface clk_ratio_checker_if;
    logic       clk2f;
    logic       clkf;
    logic       locked;
    logic       err_pulse;
    logic       sticky_err;
    logic [7:0] err_count;

    modport master (
        output clk2f, clkf,
        input  locked, err_pulse, sticky_err, err_count
    );

    modport slave (
        input  clk2f, clkf,
        output locked, err_pulse, sticky_err, err_count
    );
endinterface

// File: rtl/clk_ratio_checker.sv
// Samples clk2f/clkf as data in the clk8f domain, measures their periods and phase,
// and reports lock plus error status for self-checking of the divider chain.
module clk_ratio_checker #(
    parameter int unsigned DIV_2F       = 4,
    parameter int unsigned DIV_F        = 8,
    parameter int unsigned LOCK_PERIODS = 3,
    parameter int unsigned CNT_W        = 5
) (
    input  logic               clk8f,
    input  logic               reset,
    clk_ratio_checker_if.slave bus
);

    localparam int unsigned     RunW     = $clog2(LOCK_PERIODS + 1);
    localparam logic [RunW-1:0] LockLast = RunW'(LOCK_PERIODS - 1);

    typedef enum logic [1:0] {StAcq, StLocked, StErr} state_e;

    logic [1:0]      smp;
    logic [1:0]      rise_vec;
    logic [1:0]      bad_vec;
    logic            good_f;
    logic            bad;
    state_e          state_q, state_d;
    logic [RunW-1:0] good_run_q, good_run_d;
    logic            bad_q;
    logic            locked_q;
    logic            err_pulse_q;
    logic            sticky_q;
    logic [7:0]      err_count_q;

    // Index 0 is the clk2f channel, index 1 the clkf channel.
    assign smp = {bus.clkf, bus.clk2f};

    for (genvar i = 0; i < 2; i++) begin : g_ch
        localparam int unsigned      Div        = (i == 0) ? DIV_2F : DIV_F;
        localparam logic [CNT_W-1:0] DivLast    = CNT_W'(Div - 1);
        localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(2 * Div - 1);
        localparam logic [CNT_W-1:0] SatCnt     = CNT_W'(2 * Div);

        logic             prev_q;
        logic             armed_q, armed_d;
        logic             rise;
        logic             bad_ch;
        logic [CNT_W-1:0] cnt_q, cnt_d;

        assign rise = smp[i] & ~prev_q;

        always_comb begin
            cnt_d   = cnt_q;
            armed_d = armed_q;
            bad_ch  = 1'b0;
            if (rise) begin
                bad_ch  = armed_q && (cnt_q != DivLast);
                cnt_d   = '0;
                armed_d = 1'b1;
            end else begin
                // A stall is reported once; the next rise only re-arms.
                if (armed_q && (cnt_q == TimeoutCnt)) begin
                    bad_ch  = 1'b1;
                    armed_d = 1'b0;
                end
                if (cnt_q != SatCnt) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk8f or posedge reset) begin
            if (reset) begin
                prev_q  <= 1'b0;
                armed_q <= 1'b0;
                cnt_q   <= '0;
            end else begin
                prev_q  <= smp[i];
                armed_q <= armed_d;
                cnt_q   <= cnt_d;
            end
        end

        assign rise_vec[i] = rise;
        assign bad_vec[i]  = bad_ch;

        if (i == 1) begin : g_good
            assign good_f = rise & armed_q & (cnt_q == DivLast);
        end
    end

    // clkf must only rise together with clk2f; all sources merge into one event.
    assign bad = (|bad_vec) | (rise_vec[1] & ~rise_vec[0]);

    always_comb begin
        state_d    = state_q;
        good_run_d = good_run_q;
        unique case (state_q)
            StAcq: begin
                if (bad) begin
                    good_run_d = '0;
                end else if (good_f) begin
                    if (good_run_q == LockLast) begin
                        state_d    = StLocked;
                        good_run_d = '0;
                    end else begin
                        good_run_d = good_run_q + 1'b1;
                    end
                end
            end
            StLocked: begin
                if (bad) begin
                    state_d = StErr;
                end
            end
            StErr: begin
                state_d    = StAcq;
                good_run_d = '0;
            end
            default: begin
                state_d    = StAcq;
                good_run_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk8f or posedge reset) begin
        if (reset) begin
            state_q    <= StAcq;
            good_run_q <= '0;
        end else begin
            state_q    <= state_d;
            good_run_q <= good_run_d;
        end
    end

    // Output stage: status follows the state/event registers by one clk8f cycle.
    always_ff @(posedge clk8f or posedge reset) begin
        if (reset) begin
            bad_q       <= 1'b0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            sticky_q    <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            bad_q       <= bad;
            locked_q    <= (state_q == StLocked);
            err_pulse_q <= (state_q == StErr);
            sticky_q    <= sticky_q | (state_q == StErr);
            if (bad_q && (err_count_q != 8'hff)) begin
                err_count_q <= err_count_q + 8'd1;
            end
        end
    end

    assign bus.locked     = locked_q;
    assign bus.err_pulse  = err_pulse_q;
    assign bus.sticky_err = sticky_q;
    assign bus.err_count  = err_count_q;

endmodule

// File: doc/clk_ratio_checker.md
Name: clk_ratio_checker

Overview:
- Receive-side companion to the clock generator.
- Samples the divided clocks clk2f and clkf as data in the clk8f domain and measures each period in clk8f cycles.
- Checks the clkf/clk2f phase relationship and reports lock and error status.
- Sits beside the generator in the bench and in the design top, for self-checking of the divider chain.

Parameters:
- DIV_2F, 4: expected clk2f period in clk8f cycles.
- DIV_F, 8: expected clkf period in clk8f cycles.
- LOCK_PERIODS, 3: consecutive good clkf periods required to declare lock.
- CNT_W, 5: period counter width; must hold 2*DIV_F.

Ports:
- clk8f  input  1  fastest clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- clk2f  input  1  divided clock under test, sampled as data.
- clkf  input  1  divided clock under test, sampled as data.
- locked  output  1  high while the FSM is in LOCKED.
- err_pulse  output  1  one-cycle pulse on a LOCKED-to-ERR transition.
- sticky_err  output  1  set on any error while LOCKED; cleared only by reset.
- err_count  output  8  saturating count of all bad events after arming.

Behaviour:
- Reset (async, immediate, no clock needed): locked=0, err_pulse=0, sticky_err=0, err_count=0, FSM=ACQ.
  - Internal state also clears: counters=0, prev samples=0, armed flags=0, good_run=0.
- Per channel x in {2f, f}:
  - prev_x registers the input every cycle.
  - rise_x = x & ~prev_x, evaluated in the same cycle.
- Period counter cnt_x, on a cycle with rise_x:
  - If armed_x: good if cnt_x+1 == DIV_x, else bad.
  - Then cnt_x<=0 and armed_x<=1.
- Period counter cnt_x, on a cycle without rise_x: cnt_x<=cnt_x+1, saturating at 2*DIV_x.
- Timeout:
  - When cnt_x == 2*DIV_x-1 with no rise and armed_x, raise a bad event once and set armed_x<=0.
  - The next rise after a stall only re-arms; it is not checked.
- Phase check: a clkf rise in a cycle without a clk2f rise is a bad event. A clk2f rise without a clkf rise is legal.
- Bad events from both channels and the phase check in the same cycle count as one event.
- err_count increments by 1 per bad-event cycle in any FSM state, saturating at 255.
- FSM:
  - ACQ: each good clkf period with no bad event that cycle increments good_run. Any bad event sets good_run=0. When good_run reaches LOCK_PERIODS, go to LOCKED and clear good_run.
  - LOCKED: locked=1. On any bad event, go to ERR and set sticky_err.
  - ERR: lasts exactly one cycle with err_pulse=1, then goes to ACQ with good_run=0.
- All outputs are registered. Effects of a rise sampled at edge N are visible after edge N+1.
- A good clkf rise coinciding with a clk2f bad event is not counted toward lock.
- Reset asserted mid-operation aborts all state. Checking resumes from unarmed after deassertion.

Test Plan:
- Reset, then an ideal divider (clk2f period 4, clkf period 8, rising edges aligned):
  - The first clkf rise arms the checker.
  - locked=1 one cycle after the 4th clkf rise; err_count=0 and sticky_err=0 throughout.
- While locked, one clk2f period stretched to 5 cycles:
  - err_pulse high for exactly 1 cycle; locked drops; sticky_err=1; err_count=1.
  - The late clk2f rise also misaligns the following clkf rise. Expect err_count=2 when that misalignment counts.
  - Relock after 3 further good clkf periods; sticky_err stays 1.
- While locked, clkf held low:
  - Bad event when cnt_f reaches 15, i.e. 16 cycles after the last rise. err_pulse fires, locked=0.
  - No further increments while stalled. The resumed clkf rise only re-arms.
- clkf edges delayed 1 clk8f cycle relative to clk2f for 50 clkf periods:
  - Every clkf rise is a phase error; locked stays 0.
  - err_count increments once per clkf period.
- Assert reset between clk8f edges while locked with err_count=7:
  - All outputs read 0 before the next clk8f edge.
  - After release, a good divider relocks as in the first scenario.
- Continuous phase fault for 300 clkf periods: err_count saturates and holds at 255.
